// File: rtl/mx_arbiter.sv
// mx_arbiter: two-requester round-robin arbiter feeding a single-word output holding register
module mx_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Req1,
  input  logic [WIDTH-1:0] MI1,
  input  logic             Req2,
  input  logic [WIDTH-1:0] MI2,
  output logic             Gnt1,
  output logic             Gnt2,
  output logic             SMx,
  output logic             OutValid,
  output logic [WIDTH-1:0] OutData,
  input  logic             OutReady,
  output logic [15:0]      XferCnt
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             smx_q, smx_d;
  logic             pri_q, pri_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             cap_en, xfer;
  assign cap_en   = (state_q == IDLE) | OutReady;
  assign xfer     = (state_q == HOLD) & OutReady;
  assign Gnt1     = rst_n & cap_en & Req1 & (~Req2 | ~pri_q);
  assign Gnt2     = rst_n & cap_en & Req2 & (~Req1 | pri_q);
  assign SMx      = smx_q;
  assign OutValid = state_q == HOLD;
  assign OutData  = data_q;
  assign XferCnt  = cnt_q;
  // next state: a grant loads a new word, a consume without a grant empties the holding register
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    smx_d   = smx_q;
    pri_d   = pri_q;
    cnt_d   = xfer ? cnt_q + 16'd1 : cnt_q;
    if (Gnt1) begin
      state_d = HOLD;
      data_d  = MI1;
      smx_d   = 1'b0;
      pri_d   = 1'b1;
    end else if (Gnt2) begin
      state_d = HOLD;
      data_d  = MI2;
      smx_d   = 1'b1;
      pri_d   = 1'b0;
    end else if (xfer) begin
      state_d = IDLE;
    end
  end
  // state register; reset drops any held word without counting it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      smx_q   <= 1'b0;
      pri_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      smx_q   <= smx_d;
      pri_q   <= pri_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_mx_arbiter.sv
// tb_mx_arbiter: vector table plus scoreboard of held words and expected transfer count
module tb_mx_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Req1 = 1'b0, Req2 = 1'b0, OutReady = 1'b0;
  logic [31:0] MI1 = '0, MI2 = '0;
  logic        Gnt1, Gnt2, SMx, OutValid;
  logic [31:0] OutData;
  logic [15:0] XferCnt;
  int          checks = 0;
  int          errors = 0;
  logic [32:0] sb[$];
  logic [15:0] cnt_m = '0;

  typedef struct {
    bit          r, r1, r2;
    logic [31:0] m1, m2;
    bit          rdy, g1, g2;
  } vec_t;
  vec_t tv[20];

  mx_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .Req1(Req1), .MI1(MI1), .Req2(Req2), .MI2(MI2),
    .Gnt1(Gnt1), .Gnt2(Gnt2), .SMx(SMx), .OutValid(OutValid), .OutData(OutData),
    .OutReady(OutReady), .XferCnt(XferCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit r1, input bit r2, input logic [31:0] m1,
                      input logic [31:0] m2, input bit rdy, input bit g1, input bit g2);
    @(negedge clk);
    rst_n = r; Req1 = r1; Req2 = r2; MI1 = m1; MI2 = m2; OutReady = rdy;
    #1;
    chk("gnt1", 32'(Gnt1), 32'(g1));
    chk("gnt2", 32'(Gnt2), 32'(g2));
    if (!r) begin
      sb.delete();
      cnt_m = '0;
    end else begin
      if (sb.size() > 0 && rdy) begin
        void'(sb.pop_front());
        cnt_m++;
      end
      if (g1) sb.push_back({1'b0, m1});
      if (g2) sb.push_back({1'b1, m2});
    end
    @(posedge clk);
    #1;
    chk("outvalid", 32'(OutValid), 32'(sb.size() > 0));
    if (sb.size() > 0) begin
      chk("outdata", OutData, sb[0][31:0]);
      chk("smx", 32'(SMx), 32'(sb[0][32]));
    end
    chk("xfercnt", 32'(XferCnt), 32'(cnt_m));
  endtask

  initial begin
    tv[0]  = '{0, 1, 1, 32'h0,         32'h0,  1, 0, 0};
    tv[1]  = '{0, 0, 0, 32'h0,         32'h0,  1, 0, 0};
    tv[2]  = '{1, 1, 0, 32'hAAAA_0001, 32'h0,  1, 1, 0};
    tv[3]  = '{1, 0, 0, 32'h0,         32'h0,  1, 0, 0};
    tv[4]  = '{0, 0, 0, 32'h0,         32'h0,  1, 0, 0};
    tv[5]  = '{1, 1, 1, 32'h1,         32'h2,  1, 1, 0};
    tv[6]  = '{1, 1, 1, 32'h1,         32'h2,  1, 0, 1};
    tv[7]  = '{1, 1, 1, 32'h1,         32'h2,  1, 1, 0};
    tv[8]  = '{1, 1, 1, 32'h1,         32'h2,  1, 0, 1};
    tv[9]  = '{1, 0, 0, 32'h0,         32'h0,  1, 0, 0};
    tv[10] = '{1, 0, 0, 32'h0,         32'h0,  1, 0, 0};
    tv[11] = '{1, 0, 1, 32'h0,         32'h22, 1, 0, 1};
    tv[12] = '{1, 0, 1, 32'h0,         32'h23, 1, 0, 1};
    tv[13] = '{1, 1, 1, 32'h31,        32'h24, 1, 1, 0};
    tv[14] = '{1, 0, 0, 32'h0,         32'h0,  1, 0, 0};
    tv[15] = '{1, 1, 0, 32'h41,        32'h0,  0, 1, 0};
    tv[16] = '{1, 0, 1, 32'h0,         32'h42, 0, 0, 0};
    tv[17] = '{1, 0, 1, 32'h0,         32'h42, 1, 0, 1};
    tv[18] = '{1, 0, 0, 32'h0,         32'h0,  0, 0, 0};
    tv[19] = '{1, 0, 0, 32'h0,         32'h0,  1, 0, 0};
    foreach (tv[i]) begin
      step(tv[i].r, tv[i].r1, tv[i].r2, tv[i].m1, tv[i].m2, tv[i].rdy, tv[i].g1, tv[i].g2);
      if (!tv[i].r) chk("rst_outdata", OutData, 32'h0);
    end
    chk("cnt_after_table", 32'(XferCnt), 32'd9);
    // stalled consumer holds the word while requester 2 waits
    step(1, 1, 0, 32'hDEAD_BEEF, 32'h0, 0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      step(1, 0, 1, 32'h0, 32'hCAFE_0002, 0, 0, 0);
      chk("stall_data", OutData, 32'hDEAD_BEEF);
    end
    step(1, 0, 1, 32'h0, 32'hCAFE_0002, 1, 0, 1);
    chk("stall_newdata", OutData, 32'hCAFE_0002);
    step(1, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    // reset while holding a word with three transfers counted
    step(0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(1, 1, 0, 32'h100 + 32'(k), 32'h0, 1, 1, 0);
    chk("pre_rst_cnt", 32'(XferCnt), 32'd3);
    chk("pre_rst_valid", 32'(OutValid), 32'd1);
    step(0, 1, 1, 32'h5, 32'h6, 1, 0, 0);
    chk("rst_hold_data", OutData, 32'h0);
    chk("rst_hold_cnt", 32'(XferCnt), 32'd0);
    step(1, 1, 1, 32'h7, 32'h8, 1, 1, 0);
    step(1, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    // counter wrap through 65536 back-to-back transfers
    step(0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    for (int k = 0; k < 65536; k++) step(1, 1, 0, 32'(k), 32'h0, 1, 1, 0);
    chk("cnt_ffff", 32'(XferCnt), 32'h0000_FFFF);
    step(1, 0, 0, 32'h0, 32'h0, 1, 0, 0);
    chk("cnt_wrap", 32'(XferCnt), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mx_arbiter.md
MX_ARBITER -- requirements
Module: mx_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data path width of both sources and the output.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset, sampled on rising clk edge.
REQ-004 Req1  in  1  requester 1 has a word pending on MI1.
REQ-005 MI1  in  WIDTH  requester 1 data.
REQ-006 Req2  in  1  requester 2 has a word pending on MI2.
REQ-007 MI2  in  WIDTH  requester 2 data.
REQ-008 Gnt1  out  1  combinational; requester 1 word is captured at this clock edge.
REQ-009 Gnt2  out  1  combinational; requester 2 word is captured at this clock edge.
REQ-010 SMx  out  1  registered mux select of the held word: 0 = MI1 source, 1 = MI2 source.
REQ-011 OutValid  out  1  registered; OutData holds an unconsumed word.
REQ-012 OutData  out  WIDTH  registered held word.
REQ-013 OutReady  in  1  consumer accepts OutData on this edge when OutValid=1.
REQ-014 XferCnt  out  16  registered count of completed output transfers.

Function
REQ-015 The block SHALL have two states: IDLE (OutValid=0) and HOLD (OutValid=1).
REQ-016 Capture enable SHALL be CapEn = (state==IDLE) | OutReady.
REQ-017 With CapEn=1 and exactly one of Req1/Req2 high, the SHALL grant go to that requester.
REQ-018 With CapEn=1 and both requests high, the grant SHALL go to the requester named by the round-robin pointer Pri (0 = requester 1, 1 = requester 2).
REQ-019 At most one of Gnt1/Gnt2 SHALL be high in any cycle; both SHALL be 0 when CapEn=0 or no request is present.
REQ-020 On an edge with Gnt1=1: OutData<=MI1, SMx<=0, Pri<=1, state<=HOLD.
REQ-021 On an edge with Gnt2=1: OutData<=MI2, SMx<=1, Pri<=0, state<=HOLD.
REQ-022 Pri SHALL change only on a grant; grants without contention still update Pri per REQ-020/021.
REQ-023 In HOLD with OutReady=0: OutData, SMx and OutValid SHALL hold; no grant.
REQ-024 In HOLD with OutReady=1: XferCnt SHALL increment; if a grant occurs in the same cycle, state stays HOLD with the new word (back-to-back, one word per cycle); otherwise state<=IDLE.
REQ-025 In IDLE, OutReady SHALL be ignored and XferCnt SHALL NOT increment.
REQ-026 Latency: a word granted at edge N SHALL appear on OutData with OutValid=1 in cycle N+1.
REQ-027 XferCnt SHALL wrap from 16'hFFFF to 16'h0000 without saturating or flagging.
REQ-028 Requesters SHALL hold Req and data stable until granted; the block does not buffer ungranted requests.
REQ-029 In IDLE with no request, all registers SHALL hold.

Reset
REQ-030 When rst_n=0 at a rising edge: state<=IDLE, OutValid<=0, OutData<=0, SMx<=0, Pri<=0, XferCnt<=0.
REQ-031 While rst_n=0, Gnt1 and Gnt2 SHALL be 0 regardless of requests.
REQ-032 Reset asserted in HOLD SHALL discard the held word without counting a transfer.
REQ-033 The first grant after reset under contention SHALL go to requester 1.

Verification
REQ-034 Reset, then Req1=1 MI1=32'hAAAA_0001 for one cycle, OutReady=1 -> Gnt1=1 that cycle; next cycle OutValid=1, OutData=32'hAAAA_0001, SMx=0; following cycle OutValid=0, XferCnt=1.
REQ-035 Req1=Req2=1 held continuously, MI1=32'h1, MI2=32'h2, OutReady=1 -> grants alternate 1,2,1,2; OutData sequence 1,2,1,2 on consecutive cycles; SMx 0,1,0,1; XferCnt +1 per cycle.
REQ-036 Word 32'hDEAD_BEEF held, OutReady=0 for 5 cycles while Req2=1 -> no Gnt2, OutData stable 5 cycles; OutReady=1 -> Gnt2 same cycle, next OutData=MI2.
REQ-037 rst_n=0 asserted in HOLD with XferCnt=3 -> next cycle OutValid=0, OutData=0, XferCnt=0, Pri=0; grants suppressed during reset.
REQ-038 Force XferCnt to 16'hFFFF via 65535 transfers, one more transfer -> XferCnt=16'h0000.
REQ-039 Only Req2=1 twice in a row, then both requests -> third grant goes to requester 1 (Pri=0 after Gnt2).
